// File: rtl/rename_if.sv
// Rename stage bus: the decode pair in, commit frees, and the renamed pair out.
// Both pair channels use valid/ready: a pair moves on a rising clock edge only when valid and ready are both high, and the producer holds its payload while valid && !ready.
interface rename_if #(
  parameter int PTAG_W = 6,
  parameter int CNT_W  = 6
);
  typedef struct packed {
    logic RegWrite;
    logic MemRead;
    logic MemWrite;
    logic ALUSrc;
  } ctrl_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    ctrl_t       control;
  } instStruct;

  logic              in_valid;
  instStruct         in_a;
  instStruct         in_b;
  logic              in_ready;

  logic              free_valid_a;
  logic              free_valid_b;
  logic [PTAG_W-1:0] free_preg_a;
  logic [PTAG_W-1:0] free_preg_b;

  logic              out_valid;
  logic              out_ready;
  instStruct         out_a;
  instStruct         out_b;
  logic [PTAG_W-1:0] prs1_a;
  logic [PTAG_W-1:0] prs2_a;
  logic [PTAG_W-1:0] prd_a;
  logic [PTAG_W-1:0] old_prd_a;
  logic [PTAG_W-1:0] prs1_b;
  logic [PTAG_W-1:0] prs2_b;
  logic [PTAG_W-1:0] prd_b;
  logic [PTAG_W-1:0] old_prd_b;

  logic [CNT_W-1:0]  dbg_count;

  modport master (
    output in_valid, in_a, in_b, free_valid_a, free_valid_b, free_preg_a, free_preg_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, prs1_a, prs2_a, prd_a, old_prd_a,
           prs1_b, prs2_b, prd_b, old_prd_b, dbg_count
  );

  modport slave (
    input  in_valid, in_a, in_b, free_valid_a, free_valid_b, free_preg_a, free_preg_b, out_ready,
    output in_ready, out_valid, out_a, out_b, prs1_a, prs2_a, prd_a, old_prd_a,
           prs1_b, prs2_b, prd_b, old_prd_b, dbg_count
  );
endinterface

// File: rtl/rename.sv
// Two-wide register rename: RAT lookup, free-list allocation with intra-pair
// bypass, commit-side frees and a single registered output stage.
module rename #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32
) (
  input logic   clk,
  input logic   reset,
  rename_if.slave bus
);
  localparam int PTAG_W   = $clog2(NUM_PREGS);
  localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int FL_W     = $clog2(FL_DEPTH);
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);

  logic [PTAG_W-1:0] rat [NUM_AREGS];
  logic [PTAG_W-1:0] fl  [FL_DEPTH];
  logic [FL_W-1:0]   head;
  logic [FL_W-1:0]   tail;
  logic [CNT_W-1:0]  count;

  logic              alloc_a;
  logic              alloc_b;
  logic              accept;
  logic [1:0]        n_alloc;
  logic [PTAG_W-1:0] prd_a_n;
  logic [PTAG_W-1:0] prd_b_n;
  logic [PTAG_W-1:0] old_a_n;
  logic [PTAG_W-1:0] old_b_n;
  logic [PTAG_W-1:0] prs1_b_n;
  logic [PTAG_W-1:0] prs2_b_n;
  logic [CNT_W-1:0]  pops;
  logic [CNT_W-1:0]  cnt_after_pop;
  logic [CNT_W-1:0]  count_next;
  logic              push_a;
  logic              push_b;
  logic              wr_a;
  logic              wr_b;

  always_comb begin
    alloc_a  = bus.in_a.control.RegWrite && (bus.in_a.rd != '0);
    alloc_b  = bus.in_b.control.RegWrite && (bus.in_b.rd != '0);
    n_alloc  = {1'b0, alloc_a} + {1'b0, alloc_b};
    // Only the registered count gates acceptance; frees arriving this cycle are not usable yet.
    bus.in_ready = (!bus.out_valid || bus.out_ready) && (count >= CNT_W'(n_alloc));
    accept   = bus.in_valid && bus.in_ready;

    prd_a_n  = alloc_a ? fl[head] : '0;
    prd_b_n  = '0;
    if (alloc_b) prd_b_n = alloc_a ? fl[head + FL_W'(1)] : fl[head];

    old_a_n  = alloc_a ? rat[bus.in_a.rd] : '0;
    old_b_n  = '0;
    if (alloc_b) old_b_n = (alloc_a && (bus.in_a.rd == bus.in_b.rd)) ? prd_a_n : rat[bus.in_b.rd];

    // b sees a's fresh mapping when it reads the register a is writing.
    prs1_b_n = (alloc_a && (bus.in_b.rs1 == bus.in_a.rd)) ? prd_a_n : rat[bus.in_b.rs1];
    prs2_b_n = (alloc_a && (bus.in_b.rs2 == bus.in_a.rd)) ? prd_a_n : rat[bus.in_b.rs2];

    pops          = accept ? CNT_W'(n_alloc) : '0;
    cnt_after_pop = count - pops;
    push_a        = bus.free_valid_a && (bus.free_preg_a != '0);
    push_b        = bus.free_valid_b && (bus.free_preg_b != '0);
    // A push into a full list is dropped so the count saturates.
    wr_a          = push_a && (cnt_after_pop < CNT_W'(FL_DEPTH));
    wr_b          = push_b && ((cnt_after_pop + CNT_W'(wr_a)) < CNT_W'(FL_DEPTH));
    count_next    = cnt_after_pop + CNT_W'(wr_a) + CNT_W'(wr_b);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AREGS; i++) rat[i] <= PTAG_W'(i);
      for (int i = 0; i < FL_DEPTH; i++) fl[i] <= PTAG_W'(NUM_AREGS + i);
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(FL_DEPTH);
    end else begin
      if (accept && alloc_a) rat[bus.in_a.rd] <= prd_a_n;
      if (accept && alloc_b) rat[bus.in_b.rd] <= prd_b_n;
      if (wr_a) fl[tail] <= bus.free_preg_a;
      if (wr_b) fl[tail + FL_W'(wr_a)] <= bus.free_preg_b;
      head  <= head + FL_W'(pops);
      tail  <= tail + FL_W'(wr_a) + FL_W'(wr_b);
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_a     <= '0;
      bus.out_b     <= '0;
      bus.prs1_a    <= '0;
      bus.prs2_a    <= '0;
      bus.prd_a     <= '0;
      bus.old_prd_a <= '0;
      bus.prs1_b    <= '0;
      bus.prs2_b    <= '0;
      bus.prd_b     <= '0;
      bus.old_prd_b <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_a     <= bus.in_a;
      bus.out_b     <= bus.in_b;
      bus.prs1_a    <= rat[bus.in_a.rs1];
      bus.prs2_a    <= rat[bus.in_a.rs2];
      bus.prd_a     <= prd_a_n;
      bus.old_prd_a <= old_a_n;
      bus.prs1_b    <= prs1_b_n;
      bus.prs2_b    <= prs2_b_n;
      bus.prd_b     <= prd_b_n;
      bus.old_prd_b <= old_b_n;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  assign bus.dbg_count = count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (push_a == wr_a) && (push_b == wr_b));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(accept && (count < CNT_W'(n_alloc))));
endmodule
